// File: rtl/reg_share_arbiter_if.sv
// Request/grant bus between the write requesters and the shared-register arbiter.
interface reg_share_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] d;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      q;
    logic                  busy;
    logic [IDW-1:0]        last_id;

    modport master (
        output req, d,
        input  gnt, ack, q, busy, last_id
    );

    modport slave (
        input  req, d,
        output gnt, ack, q, busy, last_id
    );
endinterface

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter serialising writes from NREQ requesters into one shared register.
// Each write takes IDLE -> GRANT -> ACK; the requester just served drops to lowest priority.
module reg_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    reg_share_arbiter_if.slave bus
);
    localparam int SW = IDW + 1;

    typedef enum logic [1:0] {IDLE, GRANT, ACK} state_e;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [IDW-1:0]    last_id_q, last_id_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    w_q, w_d;

    logic [2*NREQ-1:0] req_rot;
    logic              win_found;
    logic [SW-1:0]     win_sum;
    logic [IDW-1:0]    win_idx;
    logic              req_w;
    logic [WIDTH-1:0]  d_w;
    logic [IDW-1:0]    ptr_next;

    // Rotate so bit 0 is the requester at ptr; the first set bit is the winner offset.
    always_comb begin
        req_rot   = {bus.req, bus.req} >> ptr_q;
        win_found = 1'b0;
        win_sum   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found && req_rot[i]) begin
                win_found = 1'b1;
                win_sum   = {1'b0, ptr_q} + SW'(i);
            end
        end
        if (win_sum >= SW'(NREQ)) begin
            win_sum = win_sum - SW'(NREQ);
        end
        win_idx = win_sum[IDW-1:0];
    end

    always_comb begin
        d_w = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_q == IDW'(i)) begin
                d_w = bus.d[i*WIDTH +: WIDTH];
            end
        end
        req_w    = |(bus.req & gnt_q);
        ptr_next = (w_q == IDW'(NREQ - 1)) ? '0 : w_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            ack_q     <= '0;
            q_q       <= '0;
            last_id_q <= '0;
            ptr_q     <= '0;
            w_q       <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            q_q       <= q_d;
            last_id_q <= last_id_d;
            ptr_q     <= ptr_d;
            w_q       <= w_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ack_d     = ack_q;
        q_d       = q_q;
        last_id_d = last_id_q;
        ptr_d     = ptr_q;
        w_d       = w_q;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                ack_d = '0;
                if (win_found) begin
                    w_d     = win_idx;
                    gnt_d   = NREQ'(1) << win_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (req_w) begin
                    q_d     = d_w;
                    ack_d   = gnt_q;
                    state_d = ACK;
                end else begin
                    // Withdrawn request: abandon without touching q or the pointer.
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            ACK: begin
                gnt_d     = '0;
                ack_d     = '0;
                last_id_d = w_q;
                ptr_d     = ptr_next;
                state_d   = IDLE;
            end
            default: begin
                gnt_d   = '0;
                ack_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.gnt     = gnt_q;
    assign bus.ack     = ack_q;
    assign bus.q       = q_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.last_id = last_id_q;

endmodule
